// File: rtl/skolem_urem_checker_if.sv
// Job/result handshake bundle for the urem Skolem checker: operands in, remainder and verdict out.
interface skolem_urem_checker_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] s;
  logic [3:0] t;
  logic [3:0] x;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] rem;
  logic       holds;

  modport master (
    output in_valid, s, t, x, out_ready,
    input  in_ready, out_valid, rem, holds
  );

  modport slave (
    input  in_valid, s, t, x, out_ready,
    output in_ready, out_valid, rem, holds
  );
endinterface

// File: rtl/skolem_urem_checker.sv
// Checks inv_ne_bvurem (x urem s != t) via 4-cycle MSB-first restoring division; result held until out_ready.
// Optional saturating failure counter on port err_cnt when SKOLEM_UREM_ERR_CNT_EN is defined.
module skolem_urem_checker (
  input logic                 clk,
  input logic                 rst_n,
  skolem_urem_checker_if.slave bus
`ifdef SKOLEM_UREM_ERR_CNT_EN
  ,
  output logic [7:0]          err_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  state_t     state_q, state_d;
  logic [3:0] s_q, s_d, t_q, t_d, x_q, x_d;
  logic [3:0] r_q, r_d, rem_q, rem_d;
  logic [1:0] idx_q, idx_d;
  logic       holds_q, holds_d;
  logic       armed_q;
  logic [4:0] r5;
  logic [3:0] diff;
  logic       accept;
  logic       done_hs;

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.rem       = rem_q;
  assign bus.holds     = holds_q;

  // armed_q blocks acceptance on the first edge after reset release.
  assign accept  = bus.in_valid & bus.in_ready & armed_q;
  assign done_hs = bus.out_valid & bus.out_ready;

  // Partial remainder stays below 16 whenever a subtraction happens, so 4 bits suffice.
  assign r5   = {r_q, x_q[idx_q]};
  assign diff = r5[3:0] - s_q;

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    t_d     = t_q;
    x_d     = x_q;
    r_d     = r_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    holds_d = holds_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          s_d     = bus.s;
          t_d     = bus.t;
          x_d     = bus.x;
          r_d     = 4'd0;
          idx_d   = 2'd3;
          state_d = DIV;
        end
      end
      DIV: begin
        r_d   = (r5 >= {1'b0, s_q}) ? diff : r5[3:0];
        idx_d = idx_q - 2'd1;
        if (idx_q == 2'd0) begin
          rem_d   = r_d;
          holds_d = (r_d != t_q);
          state_d = DONE;
        end
      end
      DONE: begin
        if (done_hs) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s_q     <= 4'd0;
      t_q     <= 4'd0;
      x_q     <= 4'd0;
      r_q     <= 4'd0;
      idx_q   <= 2'd0;
      rem_q   <= 4'd0;
      holds_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      t_q     <= t_d;
      x_q     <= x_d;
      r_q     <= r_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
      holds_q <= holds_d;
      armed_q <= 1'b1;
    end
  end

`ifdef SKOLEM_UREM_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (done_hs && !holds_q && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= 8'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_skolem_urem_checker.sv
// Scoreboard bench for skolem_urem_checker: directed jobs, backpressure, reset cases and a full 4096-triple sweep.
module tb_skolem_urem_checker;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  int   err_model;
  logic [4:0] sb_q[$];

  skolem_urem_checker_if bus ();

`ifdef SKOLEM_UREM_ERR_CNT_EN
  logic [7:0] err_cnt;
  skolem_urem_checker dut (.clk(clk), .rst_n(rst_n), .bus(bus), .err_cnt(err_cnt));
`else
  skolem_urem_checker dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] model(input logic [3:0] s, input logic [3:0] t, input logic [3:0] x);
    logic [3:0] r;
    r = (s == 4'd0) ? x : (x % s);
    return {r, (r != t)};
  endfunction

  // Drives one job, checks latency, optionally stalls the result for `hold` cycles, then retires it.
  task automatic run_job(input logic [3:0] s, input logic [3:0] t, input logic [3:0] x, input int hold);
    logic [4:0] e;
    int lat;
    bus.out_ready = (hold == 0);
    bus.s = s;
    bus.t = t;
    bus.x = x;
    bus.in_valid = 1'b1;
    chk("in_ready_idle", bus.in_ready, 1);
    sb_q.push_back(model(s, t, x));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.s = ~s;
    bus.t = ~t;
    bus.x = ~x;
    lat = 0;
    while (!bus.out_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, 4);
    for (int i = 0; i < hold; i++) begin
      chk("bp_valid", bus.out_valid, 1);
      chk("bp_in_ready", bus.in_ready, 0);
      chk("bp_rem", bus.rem, sb_q[0][4:1]);
      chk("bp_holds", bus.holds, sb_q[0][0]);
      bus.in_valid = 1'b1;
      bus.s = 4'($urandom_range(0, 15));
      bus.t = 4'($urandom_range(0, 15));
      bus.x = 4'($urandom_range(0, 15));
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 1, 0);
      e = 5'd0;
    end else begin
      e = sb_q.pop_front();
    end
    chk("out_valid", bus.out_valid, 1);
    chk("rem", bus.rem, e[4:1]);
    chk("holds", bus.holds, e[0]);
    if (!e[0] && err_model != 255) err_model++;
    @(posedge clk); #1;
    chk("post_valid", bus.out_valid, 0);
    chk("post_in_ready", bus.in_ready, 1);
    chk("retained_rem", bus.rem, e[4:1]);
    chk("retained_holds", bus.holds, e[0]);
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    err_model = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.s = 4'd0;
    bus.t = 4'd0;
    bus.x = 4'd0;
    #12;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_rem", bus.rem, 0);
    chk("rst_holds", bus.holds, 0);
`ifdef SKOLEM_UREM_ERR_CNT_EN
    chk("rst_err_cnt", err_cnt, 0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.s = 4'd3;
    bus.t = 4'd1;
    bus.x = 4'd7;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    chk("first_edge_ignored", bus.in_ready, 1);

    run_job(4'd3, 4'd1, 4'd7, 0);
    run_job(4'd0, 4'd5, 4'd9, 0);
    run_job(4'd5, 4'd0, 4'd14, 6);

    // Reset two edges into the division: job must vanish without a result.
    bus.s = 4'd7;
    bus.t = 4'd2;
    bus.x = 4'd13;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    err_model = 0;
    #1;
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_in_ready", bus.in_ready, 1);
    chk("mid_rst_rem", bus.rem, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_no_result", bus.out_valid, 0);
    run_job(4'd15, 4'd14, 4'd14, 0);

    for (int s = 0; s < 16; s++)
      for (int t = 0; t < 16; t++)
        for (int x = 0; x < 16; x++)
          run_job(4'(s), 4'(t), 4'(x), 0);

`ifdef SKOLEM_UREM_ERR_CNT_EN
    chk("err_cnt_model", err_cnt, err_model);
    chk("err_cnt_sat", err_cnt, 255);
`endif
    chk("sb_drained", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
